// File: rtl/sram_rmw_ctrl.sv
// Async-SRAM controller for the co-processor IO bus: word reads, full-word
// writes (optionally posted) and byte-lane writes done as read-modify-write.
module sram_rmw_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 19,
    parameter int RD_LAT     = 1,
    parameter int WR_LAT     = 1,
    parameter int RMW_RD_LAT = 1,
    parameter int RMW_WR_LAT = 1,
    parameter int POST_WR    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_rd,
    input  logic                  io_wr,
    input  logic [31:0]           io_a,
    input  logic [DATA_W/8-1:0]   io_be,
    input  logic [DATA_W-1:0]     io_di,
    output logic [DATA_W-1:0]     io_q,
    output logic                  io_ready,
    output logic                  busy,
    output logic                  ram_cs_b,
    output logic                  ram_oe_b,
    output logic                  ram_we_b,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_dq_o,
    output logic                  ram_dq_oe,
    input  logic [DATA_W-1:0]     ram_dq_i
);
    localparam int LANES = DATA_W / 8;
    localparam int AB    = $clog2(LANES);

    typedef enum logic [2:0] {IDLE, READ, RMW_RD, WRITE, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          lcount, lcount_nxt;
    logic                posted, posted_nxt;
    logic [LANES-1:0]    be_q, be_nxt;
    logic [DATA_W-1:0]   di_q, di_nxt;
    logic                ready_nxt, cs_nxt, oe_nxt, we_nxt, dq_oe_nxt;
    logic [DATA_W-1:0]   q_nxt, dq_nxt, merged;
    logic [ADDR_W-1:0]   addr_nxt, a_word;
    logic                lc_zero, be_full, be_none;
    logic                unused_a;

    assign a_word   = io_a[ADDR_W+AB-1:AB];
    assign unused_a = ^io_a;
    assign lc_zero  = (lcount == 3'd0);
    assign be_full  = &io_be;
    assign be_none  = ~|io_be;
    assign busy     = (state != IDLE);

    always_comb begin
        merged = ram_dq_i;
        for (int i = 0; i < LANES; i++)
            if (be_q[i]) merged[i*8 +: 8] = di_q[i*8 +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lcount    <= '0;
            posted    <= 1'b0;
            be_q      <= '0;
            di_q      <= '0;
            io_ready  <= 1'b0;
            io_q      <= '0;
            ram_cs_b  <= 1'b1;
            ram_oe_b  <= 1'b1;
            ram_we_b  <= 1'b1;
            ram_addr  <= '0;
            ram_dq_o  <= '0;
            ram_dq_oe <= 1'b0;
        end else begin
            state     <= state_nxt;
            lcount    <= lcount_nxt;
            posted    <= posted_nxt;
            be_q      <= be_nxt;
            di_q      <= di_nxt;
            io_ready  <= ready_nxt;
            io_q      <= q_nxt;
            ram_cs_b  <= cs_nxt;
            ram_oe_b  <= oe_nxt;
            ram_we_b  <= we_nxt;
            ram_addr  <= addr_nxt;
            ram_dq_o  <= dq_nxt;
            ram_dq_oe <= dq_oe_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        lcount_nxt = lcount;
        unique case (state)
            IDLE: begin
                if (io_rd) begin
                    state_nxt  = READ;
                    lcount_nxt = 3'(RD_LAT);
                end else if (io_wr) begin
                    if (be_full) begin
                        state_nxt  = WRITE;
                        lcount_nxt = 3'(WR_LAT);
                    end else if (be_none) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt  = RMW_RD;
                        lcount_nxt = 3'(RMW_RD_LAT);
                    end
                end
            end
            READ, WRITE: begin
                if (!lc_zero) lcount_nxt = lcount - 3'd1;
                else          state_nxt  = DONE;
            end
            RMW_RD: begin
                if (!lc_zero) begin
                    lcount_nxt = lcount - 3'd1;
                end else begin
                    state_nxt  = WRITE;
                    lcount_nxt = 3'(RMW_WR_LAT);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        posted_nxt = posted;
        be_nxt     = be_q;
        di_nxt     = di_q;
        ready_nxt  = 1'b0;
        q_nxt      = io_q;
        cs_nxt     = ram_cs_b;
        oe_nxt     = ram_oe_b;
        we_nxt     = ram_we_b;
        addr_nxt   = ram_addr;
        dq_nxt     = ram_dq_o;
        dq_oe_nxt  = ram_dq_oe;
        unique case (state)
            IDLE: begin
                cs_nxt    = 1'b1;
                oe_nxt    = 1'b1;
                we_nxt    = 1'b1;
                dq_oe_nxt = 1'b0;
                if (io_rd) begin
                    cs_nxt   = 1'b0;
                    oe_nxt   = 1'b0;
                    addr_nxt = a_word;
                end else if (io_wr) begin
                    be_nxt     = io_be;
                    di_nxt     = io_di;
                    posted_nxt = 1'b0;
                    if (be_full) begin
                        cs_nxt     = 1'b0;
                        we_nxt     = 1'b0;
                        addr_nxt   = a_word;
                        dq_nxt     = io_di;
                        dq_oe_nxt  = 1'b1;
                        posted_nxt = (POST_WR != 0);
                        ready_nxt  = (POST_WR != 0);
                    end else if (be_none) begin
                        ready_nxt = 1'b1;
                    end else begin
                        cs_nxt   = 1'b0;
                        oe_nxt   = 1'b0;
                        addr_nxt = a_word;
                    end
                end
            end
            READ: begin
                if (lc_zero) begin
                    q_nxt     = ram_dq_i;
                    cs_nxt    = 1'b1;
                    oe_nxt    = 1'b1;
                    we_nxt    = 1'b1;
                    ready_nxt = 1'b1;
                end
            end
            RMW_RD: begin
                // cs stays low across the turnaround from read to write
                if (lc_zero) begin
                    dq_nxt    = merged;
                    oe_nxt    = 1'b1;
                    we_nxt    = 1'b0;
                    dq_oe_nxt = 1'b1;
                end
            end
            WRITE: begin
                if (lc_zero) begin
                    cs_nxt    = 1'b1;
                    oe_nxt    = 1'b1;
                    we_nxt    = 1'b1;
                    dq_oe_nxt = 1'b0;
                    ready_nxt = !posted;
                end
            end
            DONE:    ready_nxt = 1'b0;
            default: ready_nxt = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Randomized bench for sram_rmw_ctrl: four parameter sets, each against a
// behavioural SRAM and a word-array reference model of the bus transactions.
module tb_sram_rmw_ctrl;
    localparam int AW = 9;

    logic       clk;
    int         vectors;
    int         miscompares;
    logic [3:0] done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int DW  = (g == 1 || g == 3) ? 16 : 32;
        localparam int LN  = DW / 8;
        localparam int AB  = $clog2(LN);
        localparam int RDL = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 7 : 4;
        localparam int WRL = (g == 0) ? 1 : (g == 1) ? 7 : (g == 2) ? 0 : 2;
        localparam int RRL = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 : 7;
        localparam int RWL = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 7 : 5;
        localparam int PST = (g == 1 || g == 2) ? 1 : 0;

        logic          rst, io_rd, io_wr, io_ready, busy;
        logic [31:0]   io_a;
        logic [LN-1:0] io_be;
        logic [DW-1:0] io_di, io_q, ram_dq_o, ram_dq_i;
        logic          ram_cs_b, ram_oe_b, ram_we_b, ram_dq_oe;
        logic [AW-1:0] ram_addr;
        logic [DW-1:0] mem     [512];
        logic [DW-1:0] ref_mem [512];
        logic          sync_mem;
        logic          prev_rdy;

        sram_rmw_ctrl #(
            .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RDL), .WR_LAT(WRL),
            .RMW_RD_LAT(RRL), .RMW_WR_LAT(RWL), .POST_WR(PST)
        ) dut (
            .clk(clk), .rst(rst), .io_rd(io_rd), .io_wr(io_wr),
            .io_a(io_a), .io_be(io_be), .io_di(io_di), .io_q(io_q),
            .io_ready(io_ready), .busy(busy), .ram_cs_b(ram_cs_b),
            .ram_oe_b(ram_oe_b), .ram_we_b(ram_we_b), .ram_addr(ram_addr),
            .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe), .ram_dq_i(ram_dq_i)
        );

        // Behavioural async SRAM: reads while cs&oe low, stores while cs&we low
        assign ram_dq_i = (!ram_cs_b && !ram_oe_b) ? mem[ram_addr] : '0;

        always @(negedge clk) begin
            if (sync_mem)
                for (int i = 0; i < 512; i++) mem[i] = ref_mem[i];
            else if (!ram_cs_b && !ram_we_b)
                mem[ram_addr] = ram_dq_o;
        end

        initial prev_rdy = 1'b0;
        always @(negedge clk) begin
            if (!ram_oe_b || ram_dq_oe)
                chk("oe_dq_overlap", {63'd0, !ram_oe_b && ram_dq_oe}, 64'd0);
            if (!ram_we_b)
                chk("we_without_dq_oe", {63'd0, ram_dq_oe}, 64'd1);
            if (io_ready)
                chk("ready_twice", {63'd0, prev_rdy}, 64'd0);
            prev_rdy = io_ready;
        end

        task automatic req(input bit rd, input bit wr, input int w,
                           input logic [LN-1:0] be, input logic [DW-1:0] di,
                           input bit linger);
            int k, t, cs_n, oe_n, we_n;
            int exp_k, exp_cs, exp_oe, exp_we;
            bit got;
            logic [DW-1:0] exp_q;
            exp_q = ref_mem[w];
            exp_cs = 0; exp_oe = 0; exp_we = 0;
            if (rd) begin
                exp_k = RDL + 2; exp_cs = RDL + 1; exp_oe = RDL + 1;
            end else if (be == {LN{1'b1}}) begin
                ref_mem[w] = di;
                exp_k = (PST != 0) ? 1 : WRL + 2;
                exp_cs = WRL + 1; exp_we = WRL + 1;
            end else if (be == '0) begin
                exp_k = 1;
            end else begin
                for (int i = 0; i < LN; i++)
                    if (be[i]) ref_mem[w][i*8 +: 8] = di[i*8 +: 8];
                exp_k = RRL + RWL + 3; exp_cs = RRL + RWL + 2;
                exp_oe = RRL + 1; exp_we = RWL + 1;
            end
            io_rd = rd; io_wr = wr; io_be = be; io_di = di;
            io_a = ($urandom & ~(32'h1FF << AB)) | (32'(w) << AB);
            t = 0;
            while (busy && t < 64) begin @(negedge clk); t++; end
            k = 0; cs_n = 0; oe_n = 0; we_n = 0; got = 0;
            while (!got && t < 64) begin
                @(negedge clk); t++; k++;
                cs_n += int'(!ram_cs_b); oe_n += int'(!ram_oe_b);
                we_n += int'(!ram_we_b);
                got = io_ready;
            end
            chk("ready_seen", {63'd0, got}, 64'd1);
            chk("latency", 64'(k), 64'(exp_k));
            if (rd) chk("rdata", 64'(io_q), 64'(exp_q));
            if (linger) begin
                io_rd = 1'b0; io_wr = 1'b0;
                while (busy && t < 64) begin
                    @(negedge clk); t++;
                    cs_n += int'(!ram_cs_b); oe_n += int'(!ram_oe_b);
                    we_n += int'(!ram_we_b);
                end
                chk("idle_again", {63'd0, busy}, 64'd0);
                chk("cs_cycles", 64'(cs_n), 64'(exp_cs));
                chk("oe_cycles", 64'(oe_n), 64'(exp_oe));
                chk("we_cycles", 64'(we_n), 64'(exp_we));
                chk("sram_word", 64'(mem[w]), 64'(ref_mem[w]));
            end
        endtask

        task automatic rst_mid_write(input int w, input logic [DW-1:0] di);
            int t;
            t = 0;
            while (busy && t < 64) begin @(negedge clk); t++; end
            io_wr = 1'b1; io_rd = 1'b0; io_be = '1; io_di = di;
            io_a = 32'(w) << AB;
            @(negedge clk);
            chk("pre_rst_we", {63'd0, ram_we_b}, 64'd0);
            #1 rst = 1'b1;
            #1;
            chk("rst_we", {63'd0, ram_we_b}, 64'd1);
            chk("rst_cs", {63'd0, ram_cs_b}, 64'd1);
            chk("rst_dq_oe", {63'd0, ram_dq_oe}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            io_wr = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("rst_ready", {63'd0, io_ready}, 64'd0);
            end
            rst = 1'b0;
            repeat (2) begin
                @(negedge clk);
                chk("post_rst_ready", {63'd0, io_ready}, 64'd0);
            end
            // the aborted write left the word undefined; rewrite it properly
            req(0, 1, w, '1, DW'($urandom), 1);
        endtask

        initial begin
            int op, t;
            done[g] = 1'b0;
            rst = 1'b1; io_rd = 1'b0; io_wr = 1'b0;
            io_a = '0; io_be = '0; io_di = '0;
            for (int i = 0; i < 512; i++) ref_mem[i] = DW'($urandom);
            ref_mem['h123] = DW'(32'hDEADBEEF);
            ref_mem[7]     = DW'(32'h11223344);
            sync_mem = 1'b1;
            #1;
            chk("rst_io_ready", {63'd0, io_ready}, 64'd0);
            chk("rst_busy0", {63'd0, busy}, 64'd0);
            chk("rst_io_q", 64'(io_q), 64'd0);
            chk("rst_strobes", {61'd0, ram_cs_b, ram_oe_b, ram_we_b}, 64'd7);
            chk("rst_dq_oe0", {63'd0, ram_dq_oe}, 64'd0);
            chk("rst_addr", 64'(ram_addr), 64'd0);
            chk("rst_dq_o", 64'(ram_dq_o), 64'd0);
            repeat (3) @(negedge clk);
            sync_mem = 1'b0;
            rst = 1'b0;
            @(negedge clk);

            req(1, 0, 'h123, '0, '0, 1);
            chk("deadbeef", 64'(io_q), 64'(DW'(32'hDEADBEEF)));
            req(0, 1, 5, '1, DW'(32'hCAFEF00D), 1);
            req(1, 0, 5, '0, '0, 1);
            req(0, 1, 7, LN'(4'b0101), DW'(32'hAABBCCDD), 1);
            chk("rmw_word", 64'(mem[7]), 64'(DW'(32'h11BB33DD)));
            req(0, 1, 9, '1, DW'($urandom), 0);
            req(1, 0, 9, '0, '0, 1);
            req(0, 1, 11, '0, DW'($urandom), 1);
            req(1, 1, 13, '1, DW'($urandom), 1);
            req(1, 0, 13, '0, '0, 1);
            rst_mid_write(3, DW'($urandom));

            repeat (60) begin
                op = $urandom_range(0, 4);
                case (op)
                    0:       req(1, 0, $urandom_range(0, 15), LN'($urandom),
                                 DW'($urandom), $urandom_range(0, 3) != 0);
                    1:       req(0, 1, $urandom_range(0, 15), '1,
                                 DW'($urandom), $urandom_range(0, 3) != 0);
                    2:       req(0, 1, $urandom_range(0, 15), '0,
                                 DW'($urandom), 1);
                    4:       req(1, 1, $urandom_range(0, 15), LN'($urandom),
                                 DW'($urandom), 1);
                    default: req(0, 1, $urandom_range(0, 15), LN'($urandom),
                                 DW'($urandom), $urandom_range(0, 3) != 0);
                endcase
            end
            io_rd = 1'b0; io_wr = 1'b0;
            t = 0;
            while (busy && t < 64) begin @(negedge clk); t++; end
            @(negedge clk);
            for (int i = 0; i < 16; i++)
                chk("final_word", 64'(mem[i]), 64'(ref_mem[i]));
            chk("final_123", 64'(mem['h123]), 64'(ref_mem['h123]));
            done[g] = 1'b1;
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        #2;
        for (int c = 0; c < 90000 && done != 4'hF; c++) @(posedge clk);
        chk("all_configs_done", {60'd0, done}, 64'hF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
